// File: rtl/keypad_pkg.sv
// Shared types and key-code helpers for the 4x4 keypad scan encoder.
// Codes match what the calculator's key decoder expects.
package keypad_pkg;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } key_state_t;

   typedef enum logic [1:0] {
      SCAN_NONE,
      SCAN_SINGLE,
      SCAN_MULTI
   } scan_kind_t;

   // Physical layout: row0 "1 2 3 A", row1 "4 5 6 B", row2 "7 8 9 C", row3 "* 0 # D"
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'd0;
      case ({row, col})
         4'h0: code = 4'd1;
         4'h1: code = 4'd2;
         4'h2: code = 4'd3;
         4'h3: code = KEY_A;
         4'h4: code = 4'd4;
         4'h5: code = 4'd5;
         4'h6: code = 4'd6;
         4'h7: code = KEY_B;
         4'h8: code = 4'd7;
         4'h9: code = 4'd8;
         4'hA: code = 4'd9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'd0;
         4'hE: code = KEY_HASH;
         4'hF: code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Keypad pin and key-event bundle; slave is the encoder, master is the board/consumer side.
interface keypad_scan_encoder_if;

   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] keypressed;
   logic       key_valid;
   logic       key_held;

   modport master (
      output row_in,
      input  col_out,
      input  keypressed,
      input  key_valid,
      input  key_held
   );

   modport slave (
      input  row_in,
      output col_out,
      output keypressed,
      output key_valid,
      output key_held
   );

endinterface

// File: rtl/keypad_col_scanner.sv
// Column drive and row sampling: produces one none/single/multi result per full 4-column scan.
module keypad_col_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       scan_done,
   output scan_kind_t scan_kind,
   output logic [3:0] scan_code
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [DW-1:0] dwell;
   logic [1:0]    col;
   logic [1:0]    next_col;
   logic [1:0]    acc_hits;
   logic [3:0]    acc_code;
   logic [3:0]    row_low;
   logic [2:0]    low_cnt;
   logic [1:0]    low_row;
   logic [2:0]    hit_sum;
   logic [1:0]    merged_hits;
   logic [3:0]    merged_code;
   logic          last_dwell;

   // Fold this column's rows into the running scan tally; hits saturate at 2 (= multi)
   always_comb begin
      row_low     = ~row_sync;
      low_cnt     = {2'b00, row_low[0]} + {2'b00, row_low[1]}
                  + {2'b00, row_low[2]} + {2'b00, row_low[3]};
      low_row     = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (row_low[r]) low_row = 2'(r);
      end
      hit_sum     = {1'b0, acc_hits} + low_cnt;
      merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      merged_code = (low_cnt == 3'd1) ? key_code(low_row, col) : acc_code;
      next_col    = col + 2'd1;
      last_dwell  = (dwell == DWELL_LAST);
   end

   // Rows are only trusted on the last dwell cycle, long after the synchronizer has settled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         dwell     <= '0;
         col       <= 2'd0;
         col_out   <= 4'b1110;
         acc_hits  <= 2'd0;
         acc_code  <= 4'd0;
         scan_done <= 1'b0;
         scan_kind <= SCAN_NONE;
         scan_code <= 4'd0;
      end else begin
         row_meta  <= row_in;
         row_sync  <= row_meta;
         scan_done <= 1'b0;
         if (last_dwell) begin
            dwell   <= '0;
            col     <= next_col;
            col_out <= ~(4'b0001 << next_col);
            if (col == 2'd3) begin
               scan_done <= 1'b1;
               scan_code <= merged_code;
               acc_hits  <= 2'd0;
               acc_code  <= 4'd0;
               case (merged_hits)
                  2'd0:    scan_kind <= SCAN_NONE;
                  2'd1:    scan_kind <= SCAN_SINGLE;
                  default: scan_kind <= SCAN_MULTI;
               endcase
            end else begin
               acc_hits <= merged_hits;
               acc_code <= merged_code;
            end
         end else begin
            dwell <= dwell + DW'(1);
         end
      end
   end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner with scan-level debounce; emits one key_valid strobe per accepted press.
module keypad_scan_encoder
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   keypad_scan_encoder_if.slave  kp
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

   logic        scan_done;
   scan_kind_t  scan_kind;
   logic [3:0]  scan_code;
   key_state_t  state;
   logic [CW-1:0] cnt;
   logic [3:0]  cand;
   logic [3:0]  keypressed_r;
   logic        key_valid_r;
   logic        key_held_r;

   keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (kp.row_in),
      .col_out   (kp.col_out),
      .scan_done (scan_done),
      .scan_kind (scan_kind),
      .scan_code (scan_code)
   );

   // Debounce FSM advances once per completed scan; multi-key scans never count as a press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         cand         <= 4'd0;
         keypressed_r <= 4'd0;
         key_valid_r  <= 1'b0;
         key_held_r   <= 1'b0;
      end else begin
         key_valid_r <= 1'b0;
         if (scan_done) begin
            case (state)
               IDLE: begin
                  if (scan_kind == SCAN_SINGLE) begin
                     cand  <= scan_code;
                     cnt   <= CW'(1);
                     state <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (scan_kind == SCAN_SINGLE && scan_code == cand) begin
                     if (cnt >= CNT_LAST) begin
                        cnt          <= CW'(DEBOUNCE_SCANS);
                        keypressed_r <= cand;
                        key_valid_r  <= 1'b1;
                        key_held_r   <= 1'b1;
                        state        <= PRESSED;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end else if (scan_kind == SCAN_SINGLE) begin
                     cand <= scan_code;
                     cnt  <= CW'(1);
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
               PRESSED: begin
                  if (scan_kind == SCAN_NONE) begin
                     cnt   <= CW'(1);
                     state <= RELEASE;
                  end
               end
               RELEASE: begin
                  if (scan_kind == SCAN_NONE) begin
                     if (cnt >= CNT_LAST) begin
                        cnt        <= '0;
                        key_held_r <= 1'b0;
                        state      <= IDLE;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end else begin
                     state <= PRESSED;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign kp.keypressed = keypressed_r;
   assign kp.key_valid  = key_valid_r;
   assign kp.key_held   = key_held_r;

endmodule
